// File: rtl/lampFPU_pkg.sv
// Shared widths, constants and small types for the lampFPU bfloat16 datapath.
// Operand layout is {sign, exp[7:0], frac[6:0]}; the sqrt core works in unsigned Q1.15.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_DW     = 16;
  localparam int LAMP_FLOAT_E_DW   = 8;
  localparam int LAMP_FLOAT_F_DW   = 7;
  localparam int LAMP_FLOAT_S_DW   = LAMP_FLOAT_F_DW + 1;
  localparam int LAMP_SQRT_DW      = 16;
  localparam int LAMP_FLOAT_E_BIAS = 127;

  localparam logic [LAMP_FLOAT_DW-1:0] QNAN     = 16'h7FC0;
  localparam logic [LAMP_FLOAT_DW-1:0] PLUS_INF = 16'h7F80;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ZERO   = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ROUND = 2'd3
  } sqrt_state_e;

  // Denormals (exp=0) are flushed and therefore classified as zero.
  function automatic op_class_e classify(input logic [LAMP_FLOAT_E_DW-1:0] e,
                                         input logic [LAMP_FLOAT_F_DW-1:0] f);
    op_class_e c;
    if (e == '0)
      c = ZERO;
    else if (e == '1)
      c = (f == '0) ? INF : NAN;
    else
      c = NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/sqrt_norm_round.sv
// Combinational back end: normalises the core's Q1.15 result, rounds to nearest-even
// and packs it, or substitutes the fixed result for special operands.
module sqrt_norm_round
  import lampFPU_pkg::*;
(
  input  op_class_e                   op_class,
  input  logic                        sign,
  input  logic                        inv_sqrt,
  input  logic [LAMP_FLOAT_E_DW-1:0]  pre_exp,
  input  logic [LAMP_SQRT_DW-1:0]     sqrt_res,
  output logic [LAMP_FLOAT_DW-1:0]    res,
  output logic                        invalid,
  output logic                        div_by_zero
);

  logic [LAMP_FLOAT_F_DW-1:0] frac_win   [3];
  logic                       guard_win  [3];
  logic                       sticky_win [3];

  logic [1:0]                 lz;
  logic [LAMP_FLOAT_F_DW-1:0] frac_sel;
  logic                       guard_sel;
  logic                       sticky_sel;
  logic                       round_up;
  logic [LAMP_FLOAT_F_DW:0]   frac_rnd;
  logic [LAMP_FLOAT_E_DW-1:0] exp_norm;
  logic [LAMP_FLOAT_DW-1:0]   norm_res;

  // Window gi is the fraction/guard/sticky view after a left shift by gi.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win
      assign frac_win[gi]   = sqrt_res[14-gi -: LAMP_FLOAT_F_DW];
      assign guard_win[gi]  = sqrt_res[7-gi];
      assign sticky_win[gi] = |sqrt_res[6-gi:0];
    end
  endgenerate

  always_comb begin
    lz         = 2'd2;
    frac_sel   = frac_win[2];
    guard_sel  = guard_win[2];
    sticky_sel = sticky_win[2];
    if (sqrt_res[15]) begin
      lz         = 2'd0;
      frac_sel   = frac_win[0];
      guard_sel  = guard_win[0];
      sticky_sel = sticky_win[0];
    end else if (sqrt_res[14]) begin
      lz         = 2'd1;
      frac_sel   = frac_win[1];
      guard_sel  = guard_win[1];
      sticky_sel = sticky_win[1];
    end
  end

  // A carry out of the fraction leaves it all-zero and bumps the exponent.
  assign round_up = guard_sel & (sticky_sel | frac_sel[0]);
  assign frac_rnd = {1'b0, frac_sel} + {{LAMP_FLOAT_F_DW{1'b0}}, round_up};
  assign exp_norm = pre_exp - {6'b0, lz} + {7'b0, frac_rnd[LAMP_FLOAT_F_DW]};
  assign norm_res = {1'b0, exp_norm, frac_rnd[LAMP_FLOAT_F_DW-1:0]};

  always_comb begin
    res         = '0;
    invalid     = 1'b0;
    div_by_zero = 1'b0;
    if (op_class == NAN || (sign && op_class != ZERO)) begin
      res     = QNAN;
      invalid = 1'b1;
    end else if (op_class == ZERO) begin
      if (inv_sqrt) begin
        res         = {sign, PLUS_INF[LAMP_FLOAT_DW-2:0]};
        div_by_zero = 1'b1;
      end else begin
        res = {sign, {(LAMP_FLOAT_DW-1){1'b0}}};
      end
    end else if (op_class == INF) begin
      res = inv_sqrt ? '0 : PLUS_INF;
    end else if (sqrt_res != '0) begin
      res = norm_res;
    end
  end

endmodule

// File: rtl/sqrt_operand_ctrl.sv
// Operand front end and result back end around an iterative sqrt / rsqrt core:
// registers and classifies the operand, issues it, then rounds and packs the result.
module sqrt_operand_ctrl
  import lampFPU_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        doOp_i,
  input  logic                        invSqrt_i,
  input  logic [LAMP_FLOAT_DW-1:0]    op_i,
  output logic                        busy_o,
  output logic                        doSqrt_o,
  output logic [LAMP_FLOAT_S_DW-1:0]  s_o,
  output logic                        is_exp_odd_o,
  output logic                        invSqrt_o,
  output logic                        special_case_o,
  input  logic                        sqrt_valid_i,
  input  logic [LAMP_SQRT_DW-1:0]     sqrt_res_i,
  output logic                        valid_o,
  output logic [LAMP_FLOAT_DW-1:0]    res_o,
  output logic                        invalid_o,
  output logic                        divByZero_o
);

  sqrt_state_e state_reg, state_next;

  logic                       accept;
  logic                       op_sign;
  logic [LAMP_FLOAT_E_DW-1:0] op_exp;
  logic [LAMP_FLOAT_F_DW-1:0] op_frac;
  op_class_e                  class_next;
  logic [LAMP_FLOAT_E_DW:0]   e_unb;
  logic [LAMP_FLOAT_E_DW-1:0] pre_exp_next;
  logic                       special_next;

  logic                       sign_reg;
  op_class_e                  class_reg;
  logic [LAMP_FLOAT_E_DW-1:0] pre_exp_reg;
  logic [LAMP_FLOAT_S_DW-1:0] s_reg;
  logic                       odd_reg;
  logic                       inv_reg;
  logic                       special_reg;
  logic [LAMP_SQRT_DW-1:0]    core_res_reg;

  logic                       valid_reg;
  logic [LAMP_FLOAT_DW-1:0]   res_reg;
  logic                       invalid_reg;
  logic                       dbz_reg;

  logic [LAMP_FLOAT_DW-1:0]   rnd_res;
  logic                       rnd_invalid;
  logic                       rnd_dbz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (doOp_i) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (sqrt_valid_i) state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_reg != IDLE);
    doSqrt_o = (state_reg == ISSUE);
  end

  assign accept  = (state_reg == IDLE) && doOp_i;
  assign op_sign = op_i[LAMP_FLOAT_DW-1];
  assign op_exp  = op_i[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
  assign op_frac = op_i[LAMP_FLOAT_F_DW-1:0];

  // e_unb is the signed unbiased exponent; e_unb[8:1] is its arithmetic half.
  assign class_next   = classify(op_exp, op_frac);
  assign e_unb        = {1'b0, op_exp} - (LAMP_FLOAT_E_DW+1)'(LAMP_FLOAT_E_BIAS);
  assign pre_exp_next = invSqrt_i
                      ? LAMP_FLOAT_E_DW'(LAMP_FLOAT_E_BIAS) - e_unb[LAMP_FLOAT_E_DW:1]
                      : LAMP_FLOAT_E_DW'(LAMP_FLOAT_E_BIAS) + e_unb[LAMP_FLOAT_E_DW:1];
  assign special_next = (class_next != NORMAL) || (op_sign && class_next != ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_reg     <= 1'b0;
      class_reg    <= NORMAL;
      pre_exp_reg  <= '0;
      s_reg        <= '0;
      odd_reg      <= 1'b0;
      inv_reg      <= 1'b0;
      special_reg  <= 1'b0;
      core_res_reg <= '0;
    end else begin
      if (accept) begin
        sign_reg    <= op_sign;
        class_reg   <= class_next;
        pre_exp_reg <= pre_exp_next;
        s_reg       <= {1'b1, op_frac};
        odd_reg     <= e_unb[0];
        inv_reg     <= invSqrt_i;
        special_reg <= special_next;
      end
      if (state_reg == WAIT && sqrt_valid_i)
        core_res_reg <= sqrt_res_i;
    end
  end

  sqrt_norm_round u_norm_round (
    .op_class    (class_reg),
    .sign        (sign_reg),
    .inv_sqrt    (inv_reg),
    .pre_exp     (pre_exp_reg),
    .sqrt_res    (core_res_reg),
    .res         (rnd_res),
    .invalid     (rnd_invalid),
    .div_by_zero (rnd_dbz)
  );

  // Result and flags are captured leaving ROUND and held until the next result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg   <= 1'b0;
      res_reg     <= '0;
      invalid_reg <= 1'b0;
      dbz_reg     <= 1'b0;
    end else begin
      valid_reg <= (state_reg == ROUND);
      if (state_reg == ROUND) begin
        res_reg     <= rnd_res;
        invalid_reg <= rnd_invalid;
        dbz_reg     <= rnd_dbz;
      end
    end
  end

  assign s_o            = s_reg;
  assign is_exp_odd_o   = odd_reg;
  assign invSqrt_o      = inv_reg;
  assign special_case_o = special_reg;
  assign valid_o        = valid_reg;
  assign res_o          = res_reg;
  assign invalid_o      = invalid_reg;
  assign divByZero_o    = dbz_reg;

endmodule

// File: tb/tb_sqrt_operand_ctrl.sv
// Directed bench for sqrt_operand_ctrl: the bench plays the sqrt core and checks
// every packed result against hand-computed bfloat16 values.
module tb_sqrt_operand_ctrl;

  logic        clk;
  logic        rst;
  logic        doOp_i;
  logic        invSqrt_i;
  logic [15:0] op_i;
  logic        busy_o;
  logic        doSqrt_o;
  logic [7:0]  s_o;
  logic        is_exp_odd_o;
  logic        invSqrt_o;
  logic        special_case_o;
  logic        sqrt_valid_i;
  logic [15:0] sqrt_res_i;
  logic        valid_o;
  logic [15:0] res_o;
  logic        invalid_o;
  logic        divByZero_o;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;

  sqrt_operand_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .doOp_i         (doOp_i),
    .invSqrt_i      (invSqrt_i),
    .op_i           (op_i),
    .busy_o         (busy_o),
    .doSqrt_o       (doSqrt_o),
    .s_o            (s_o),
    .is_exp_odd_o   (is_exp_odd_o),
    .invSqrt_o      (invSqrt_o),
    .special_case_o (special_case_o),
    .sqrt_valid_i   (sqrt_valid_i),
    .sqrt_res_i     (sqrt_res_i),
    .valid_o        (valid_o),
    .res_o          (res_o),
    .invalid_o      (invalid_o),
    .divByZero_o    (divByZero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (valid_o) valid_cnt <= valid_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One full operation; exp_odd < 0 means parity is not checked.
  task automatic do_op(input string tag, input logic [15:0] op, input logic inv,
                       input logic [15:0] core, input int wcyc, input logic poke,
                       input logic [15:0] exp_res, input logic exp_inval,
                       input logic exp_dbz, input logic exp_spec, input int exp_odd);
    int cnt0;
    cnt0 = valid_cnt;
    @(negedge clk);
    doOp_i = 1'b1; invSqrt_i = inv; op_i = op;
    @(negedge clk);
    doOp_i = 1'b0; invSqrt_i = ~inv; op_i = 16'hFFFF;
    #1;
    check_eq({tag, ".doSqrt"}, doSqrt_o, 1);
    check_eq({tag, ".busy"}, busy_o, 1);
    check_eq({tag, ".special"}, special_case_o, exp_spec);
    check_eq({tag, ".s"}, s_o, {1'b1, op[6:0]});
    check_eq({tag, ".inv"}, invSqrt_o, inv);
    if (exp_odd >= 0) check_eq({tag, ".odd"}, is_exp_odd_o, exp_odd[0]);
    @(negedge clk);
    if (poke) begin doOp_i = 1'b1; invSqrt_i = 1'b1; op_i = 16'h3F80; end
    #1;
    check_eq({tag, ".wait_doSqrt"}, doSqrt_o, 0);
    repeat (wcyc) @(negedge clk);
    doOp_i = 1'b0;
    sqrt_valid_i = 1'b1; sqrt_res_i = core;
    @(negedge clk);
    sqrt_valid_i = 1'b0; sqrt_res_i = 16'hDEAD;
    #1;
    check_eq({tag, ".round_valid"}, valid_o, 0);
    check_eq({tag, ".round_busy"}, busy_o, 1);
    @(negedge clk); #1;
    check_eq({tag, ".valid"}, valid_o, 1);
    check_eq({tag, ".res"}, res_o, exp_res);
    check_eq({tag, ".invalid"}, invalid_o, exp_inval);
    check_eq({tag, ".dbz"}, divByZero_o, exp_dbz);
    check_eq({tag, ".idle_busy"}, busy_o, 0);
    @(negedge clk); #1;
    check_eq({tag, ".valid_drop"}, valid_o, 0);
    check_eq({tag, ".res_hold"}, res_o, exp_res);
    check_eq({tag, ".s_hold"}, s_o, {1'b1, op[6:0]});
    check_eq({tag, ".pulses"}, valid_cnt - cnt0, 1);
    $display("op %-14s in=%h inv=%b core=%h -> res=%h inv_flag=%b dbz=%b",
             tag, op, inv, core, res_o, invalid_o, divByZero_o);
  endtask

  initial begin
    rst = 1'b0; doOp_i = 1'b1; invSqrt_i = 1'b1; op_i = 16'h4080;
    sqrt_valid_i = 1'b0; sqrt_res_i = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst.busy", busy_o, 0);
    check_eq("rst.doSqrt", doSqrt_o, 0);
    check_eq("rst.valid", valid_o, 0);
    check_eq("rst.res", res_o, 0);
    check_eq("rst.flags", {invalid_o, divByZero_o, special_case_o, is_exp_odd_o, invSqrt_o}, 0);
    check_eq("rst.s", s_o, 0);
    doOp_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_op("sqrt4",        16'h4080, 0, 16'h8000, 0, 0, 16'h4000, 0, 0, 0, 0);
    do_op("sqrt2",        16'h4000, 0, 16'hB505, 1, 0, 16'h3FB5, 0, 0, 0, 1);
    do_op("sqrt_neg1",    16'hBF80, 0, 16'h8000, 0, 0, 16'h7FC0, 1, 0, 1, -1);
    do_op("rsqrt_pz",     16'h0000, 1, 16'h0000, 0, 0, 16'h7F80, 0, 1, 1, -1);
    do_op("sqrt1_carry",  16'h3F80, 0, 16'hFF80, 2, 0, 16'h4000, 0, 0, 0, 0);
    do_op("rsqrt4",       16'h4080, 1, 16'h8000, 0, 0, 16'h3F00, 0, 0, 0, 0);
    do_op("rsqrt2",       16'h4000, 1, 16'h5A82, 3, 0, 16'h3F35, 0, 0, 0, 1);
    do_op("lz2",          16'h3F80, 0, 16'h3000, 0, 0, 16'h3EC0, 0, 0, 0, 0);
    do_op("tie_even",     16'h3F80, 0, 16'h8080, 0, 0, 16'h3F80, 0, 0, 0, 0);
    do_op("tie_odd",      16'h3F80, 0, 16'h8180, 0, 0, 16'h3F82, 0, 0, 0, 0);
    do_op("sticky",       16'h3F80, 0, 16'h8081, 1, 0, 16'h3F81, 0, 0, 0, 0);
    do_op("sqrt_minnorm", 16'h0080, 0, 16'h8000, 0, 0, 16'h2000, 0, 0, 0, 0);
    do_op("rsqrt_big",    16'h7F00, 1, 16'h5A82, 0, 0, 16'h1FB5, 0, 0, 0, 1);
    do_op("sqrt_pinf",    16'h7F80, 0, 16'h8000, 0, 0, 16'h7F80, 0, 0, 1, -1);
    do_op("rsqrt_pinf",   16'h7F80, 1, 16'h8000, 0, 0, 16'h0000, 0, 0, 1, -1);
    do_op("rsqrt_nan",    16'h7FC1, 1, 16'h8000, 0, 0, 16'h7FC0, 1, 0, 1, -1);
    do_op("sqrt_mz",      16'h8000, 0, 16'h8000, 0, 0, 16'h8000, 0, 0, 1, -1);
    do_op("rsqrt_mz",     16'h8000, 1, 16'h8000, 0, 0, 16'hFF80, 0, 1, 1, -1);
    do_op("sqrt_minf",    16'hFF80, 0, 16'h8000, 0, 0, 16'h7FC0, 1, 0, 1, -1);
    do_op("rsqrt_neg",    16'hC080, 1, 16'h8000, 0, 0, 16'h7FC0, 1, 0, 1, -1);
    do_op("core_zero",    16'h4080, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
    do_op("denorm",       16'h0005, 0, 16'h8000, 0, 0, 16'h0000, 0, 0, 1, -1);
    do_op("poke_wait",    16'h4000, 0, 16'hB505, 2, 1, 16'h3FB5, 0, 0, 0, 1);

    // Asynchronous reset while the core is busy aborts the operation.
    begin
      int cnt0;
      cnt0 = valid_cnt;
      @(negedge clk);
      doOp_i = 1'b1; invSqrt_i = 1'b0; op_i = 16'h4080;
      @(negedge clk);
      doOp_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("abort.busy", busy_o, 0);
      check_eq("abort.doSqrt", doSqrt_o, 0);
      check_eq("abort.res", res_o, 0);
      check_eq("abort.s", s_o, 0);
      @(negedge clk);
      rst = 1'b1;
      sqrt_valid_i = 1'b1; sqrt_res_i = 16'h8000;
      @(negedge clk);
      sqrt_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("abort.idle_busy", busy_o, 0);
      check_eq("abort.pulses", valid_cnt - cnt0, 0);
      $display("op %-14s in=%h reset in WAIT, busy=%b res=%h", "abort", 16'h4080, busy_o, res_o);
    end
    do_op("after_abort",  16'h4000, 0, 16'hB505, 0, 0, 16'h3FB5, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
